// File: rtl/xgmii_pkg.sv
// -----------------------------------------------------------------------------
// xgmii_pkg
// Shared XGMII definitions for the transmit arbiter:
//   - control-character and idle/error word constants
//   - is_start / has_term word classifiers
//   - arbiter state enum
// -----------------------------------------------------------------------------
package xgmii_pkg;

   localparam logic [63:0] XGMII_IDLE_D  = 64'h0707_0707_0707_0707;
   localparam logic [7:0]  XGMII_IDLE_C  = 8'hFF;
   localparam logic [7:0]  XGMII_START   = 8'hFB;
   localparam logic [7:0]  XGMII_TERM    = 8'hFD;
   localparam logic [7:0]  XGMII_ERROR   = 8'hFE;
   localparam logic [63:0] XGMII_ERROR_D = {8{XGMII_ERROR}};
   localparam logic [7:0]  XGMII_ERROR_C = 8'hFF;

   typedef enum logic [1:0] {
      ST_ARB  = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2,
      ST_IFG  = 2'd3
   } arb_state_e;

   // Frame start is only recognised in lane 0; a lane-4 start is treated as
   // ordinary data.
   function automatic logic is_start(input logic [63:0] data, input logic [7:0] ctrl);
      return ctrl[0] && (data[7:0] == XGMII_START);
   endfunction

   // A terminate control character in any lane ends the frame.
   function automatic logic has_term(input logic [63:0] data, input logic [7:0] ctrl);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (ctrl[i] && (data[8*i +: 8] == XGMII_TERM)) begin
            found = 1'b1;
         end
      end
      return found;
   endfunction

endpackage

// File: rtl/xgmii_tx_arbiter.sv
// -----------------------------------------------------------------------------
// xgmii_tx_arbiter
// Frame-aware two-source arbiter onto one 64-bit XGMII transmit lane. Whole
// frames are granted round-robin and forwarded unchanged, followed by an
// inter-frame gap of idles. A source that stalls mid-frame gets an error word
// on the output and the remainder of its frame is discarded.
//
// Parameters:
//   IFG_WORDS  idle cycles spent in the IFG state after each frame (>= 1)
//   CNT_W      width of the saturating status counters
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   s0_* / s1_*           source data/ctrl/valid in, ready out
//   out_data, out_ctrl    registered XGMII output word
//   grant                 one-hot owner of the current frame (0 outside PASS/DROP)
//   underrun_cnt          frames aborted by a mid-frame stall
//   stray_cnt             cycles in which non-start heads were drained in ARB
//
// Handshake: a source word transfers on a clock edge where sN_valid and
// sN_ready are both high. sN_ready may depend combinationally on sN_valid and
// the head word (ARB only); sources must hold data/ctrl stable while waiting.
// -----------------------------------------------------------------------------
module xgmii_tx_arbiter
   import xgmii_pkg::*;
#(
   parameter int IFG_WORDS = 1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [63:0]      s0_data,
   input  logic [7:0]       s0_ctrl,
   input  logic             s0_valid,
   output logic             s0_ready,
   input  logic [63:0]      s1_data,
   input  logic [7:0]       s1_ctrl,
   input  logic             s1_valid,
   output logic             s1_ready,
   output logic [63:0]      out_data,
   output logic [7:0]       out_ctrl,
   output logic [1:0]       grant,
   output logic [CNT_W-1:0] underrun_cnt,
   output logic [CNT_W-1:0] stray_cnt
);

   localparam int IFG_CW = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;
   localparam logic [IFG_CW-1:0] IFG_LAST = IFG_CW'(IFG_WORDS - 1);

   // Sources as 2-element arrays so both are handled by the same logic.
   logic [63:0] src_data  [2];
   logic [7:0]  src_ctrl  [2];
   logic [1:0]  src_valid;
   logic [1:0]  src_start;
   logic [1:0]  src_ready;

   assign src_data[0] = s0_data;
   assign src_data[1] = s1_data;
   assign src_ctrl[0] = s0_ctrl;
   assign src_ctrl[1] = s1_ctrl;
   assign src_valid   = {s1_valid, s0_valid};
   assign s0_ready    = src_ready[0];
   assign s1_ready    = src_ready[1];

   arb_state_e        state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   logic              last_q, last_d;      // index of the source granted most recently
   logic [IFG_CW-1:0] ifg_cnt_q, ifg_cnt_d;
   logic [63:0]       out_data_q, out_data_d;
   logic [7:0]        out_ctrl_q, out_ctrl_d;
   logic [CNT_W-1:0]  underrun_q, stray_q;
   logic              underrun_inc, stray_inc;
   logic              sel;                 // index of the granted source
   logic              winner;

   assign sel = grant_q[1];

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         src_start[i] = src_valid[i] && is_start(src_data[i], src_ctrl[i]);
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_d       = last_q;
      ifg_cnt_d    = ifg_cnt_q;
      out_data_d   = XGMII_IDLE_D;
      out_ctrl_d   = XGMII_IDLE_C;
      src_ready    = 2'b00;
      underrun_inc = 1'b0;
      stray_inc    = 1'b0;
      winner       = 1'b0;

      case (state_q)
         ST_ARB: begin
            // Drain any head that cannot open a frame; start heads stay put
            // and are consumed from PASS.
            for (int i = 0; i < 2; i++) begin
               src_ready[i] = src_valid[i] && !src_start[i];
            end
            stray_inc = |src_ready;
            if (|src_start) begin
               if (&src_start) begin
                  winner = ~last_q;
               end else begin
                  winner = src_start[1];
               end
               grant_d = winner ? 2'b10 : 2'b01;
               last_d  = winner;
               state_d = ST_PASS;
            end
         end

         ST_PASS: begin
            src_ready[sel] = 1'b1;
            if (src_valid[sel]) begin
               out_data_d = src_data[sel];
               out_ctrl_d = src_ctrl[sel];
               if (has_term(src_data[sel], src_ctrl[sel])) begin
                  grant_d   = 2'b00;
                  ifg_cnt_d = '0;
                  state_d   = ST_IFG;
               end
            end else begin
               out_data_d   = XGMII_ERROR_D;
               out_ctrl_d   = XGMII_ERROR_C;
               underrun_inc = 1'b1;
               state_d      = ST_DROP;
            end
         end

         ST_DROP: begin
            src_ready[sel] = 1'b1;
            if (src_valid[sel] && has_term(src_data[sel], src_ctrl[sel])) begin
               grant_d   = 2'b00;
               ifg_cnt_d = '0;
               state_d   = ST_IFG;
            end
         end

         ST_IFG: begin
            if (ifg_cnt_q == IFG_LAST) begin
               state_d = ST_ARB;
            end else begin
               ifg_cnt_d = ifg_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_ARB;
            grant_d = 2'b00;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_ARB;
         grant_q    <= 2'b00;
         last_q     <= 1'b1;      // source 0 wins the first tie after reset
         ifg_cnt_q  <= '0;
         out_data_q <= XGMII_IDLE_D;
         out_ctrl_q <= XGMII_IDLE_C;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         ifg_cnt_q  <= ifg_cnt_d;
         out_data_q <= out_data_d;
         out_ctrl_q <= out_ctrl_d;
      end
   end

   // Status counters saturate at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_q <= '0;
         stray_q    <= '0;
      end else begin
         if (underrun_inc && (underrun_q != '1)) begin
            underrun_q <= underrun_q + 1'b1;
         end
         if (stray_inc && (stray_q != '1)) begin
            stray_q <= stray_q + 1'b1;
         end
      end
   end

   assign out_data     = out_data_q;
   assign out_ctrl     = out_ctrl_q;
   assign grant        = grant_q;
   assign underrun_cnt = underrun_q;
   assign stray_cnt    = stray_q;

endmodule

// File: doc/xgmii_tx_arbiter.md
# xgmii_tx_arbiter

Frame-aware two-input arbiter that shares one 64-bit XGMII transmit lane between two frame sources, such as NTP responder and ARP/ICMP responder output FIFOs. It grants whole frames in round-robin order, forwards them unchanged, and inserts a minimum inter-frame gap of idles. Mid-frame underrun is replaced by an error word and the rest of that frame is discarded. The output feeds the XGMII clock-domain-crossing FIFO on the MAC/PCS side.

## Interface
- IFG_WORDS, 1: idle words the IFG state holds after each frame; must be ≥1.
- CNT_W, 16: width of the status counters.

- clk  in  1  core clock; all logic is synchronous to it.
- rst_n  in  1  asynchronous, active-low reset.
- s0_data  in  64  source 0 XGMII data; lane i is bits [8i+7:8i].
- s0_ctrl  in  8  source 0 XGMII control; bit i belongs to lane i.
- s0_valid  in  1  source 0 head word is present.
- s0_ready  out  1  source 0 head word is consumed this cycle.
- s1_data, s1_ctrl, s1_valid, s1_ready: same as source 0, for source 1.
- out_data  out  64  registered XGMII data; reset value 0x0707070707070707.
- out_ctrl  out  8  registered XGMII control; reset value 0xFF.
- grant  out  2  one-hot owner of the current frame; 0 outside PASS/DROP; reset value 0.
- underrun_cnt  out  CNT_W  frames aborted by underrun; saturating; reset value 0.
- stray_cnt  out  CNT_W  non-start words discarded in ARB; saturating; reset value 0.

## Operation
- Word classes:
  - start: ctrl[0]=1 and data[7:0]=0xFB. A start in lane 4 is not recognised.
  - term: any lane i with ctrl[i]=1 and byte i = 0xFD.
  - idle word: data 0x07 in all lanes, ctrl 0xFF.
  - error word: data 0xFE in all lanes, ctrl 0xFF.
- States are ARB, PASS, DROP and IFG. Reset enters ARB.
- ARB:
  - Output is idle.
  - For each source, s_ready = valid && !start, so stray heads are drained. stray_cnt increments by 1 per cycle, even if both sources drain in the same cycle.
  - If any source has a valid start head, latch the winner into grant and go to PASS. The start word is not consumed in ARB.
  - Round-robin tie-break: with both sources showing start, the source not granted last wins. After reset, source 0 wins the first tie.
- PASS:
  - Granted source has ready=1; the other source has ready=0.
  - When valid, the word is forwarded to the output unchanged. Any start inside a frame is forwarded as data.
  - If that word has term, go to IFG. A start word that also has term is a complete frame.
  - If valid=0, output one error word, increment underrun_cnt and go to DROP.
- DROP:
  - Granted source has ready=1; its words are discarded and the output is idle.
  - When a word with term is consumed, go to IFG.
- IFG:
  - Output is idle and both ready signals are 0.
  - Stay IFG_WORDS cycles, then go to ARB. grant clears on entry to IFG.
- Counters saturate at all-ones.
- Asserting rst_n mid-frame immediately forces out_data/out_ctrl to idle, grant to 0 and the counters to 0. The truncated frame is not terminated. This is accepted because downstream PCS treats the missing term as a frame error.

## Timing
- s_ready depends combinationally on s_valid and the head word, in ARB only. There is no combinational path from any input to out_data/out_ctrl.
- Latency: a start head first valid in ARB at cycle N is consumed at N+1 and appears on the output at N+2.
- Within a frame, throughput is 1 word/cycle. Output lags the accepted input by exactly 1 cycle.
- Inter-frame gap:
  - Back-to-back frames from either source are separated by exactly IFG_WORDS+1 idle words on the output.
  - After an underrun, the error word is followed by at least IFG_WORDS+1 idles.
- grant changes only on the ARB→PASS and PASS/DROP→IFG edges.

## Structure
- Package xgmii_pkg holds:
  - constants XGMII_IDLE_D, XGMII_IDLE_C, XGMII_START (0xFB), XGMII_TERM (0xFD) and XGMII_ERROR (0xFE);
  - functions is_start(data, ctrl) and has_term(data, ctrl);
  - the arbiter state enum.
- Single module with no sub-modules. The two sources are handled as 2-element arrays internally.

## Test plan
- Single frame: s0 sends start word, 3 data words, then a term word in lane 5. Required: out equals those 5 words starting 2 cycles after s0_valid; grant=01; counters stay 0.
- Contention: both sources hold 2-word frames continuously (3 frames each). Required: output order s0,s1,s0,s1,s0,s1 with exactly IFG_WORDS+1 idles between frames (check at IFG_WORDS=1 and 3).
- Underrun: s1 drops valid after its 2nd word, then resumes with 2 words ending in term. Required:
  - one error word (0xFE×8, ctrl 0xFF) follows the 2nd word;
  - the resumed words are discarded;
  - underrun_cnt=1, followed by IFG idles.
- Stray: s0 presents 4 data-only words (ctrl 0x00) in ARB. Required: all 4 drained, output stays idle, stray_cnt=4.
- Reset mid-frame: drop rst_n during PASS word 2. Required: out is idle and grant=0 in the same cycle. After release, the next start is accepted from ARB with source 0 winning a tie.
